// File: rtl/updn_counter_param.sv
// rtl/updn_counter_param.sv - parametrised up/down counter with runtime modulus, step, load and wrap/saturate events
module updn_counter_param #(
    parameter int          WIDTH       = 8,
    parameter int          STEP_W      = 4,
    parameter int          SATURATE    = 0,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              reverse,
    input  logic              clear,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    output logic [WIDTH-1:0]  value,
    output logic              at_zero,
    output logic              at_limit,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VALUE);

    // All arithmetic is one bit wider than the counter so limit+1 and
    // value+step never lose their carry before being compared.
    logic [WIDTH:0] lim_x;
    logic [WIDTH:0] lim_p1;
    logic [WIDTH:0] val_x;
    logic [WIDTH:0] step_x;
    logic [WIDTH:0] s_eff;
    logic [WIDTH:0] sum_up;
    logic [WIDTH:0] wrap_up;
    logic [WIDTH:0] wrap_dn;
    logic [WIDTH:0] diff_dn;

    logic [WIDTH-1:0] next_value;
    logic             next_overflow;
    logic             next_underflow;

    assign lim_x   = {1'b0, limit};
    assign lim_p1  = lim_x + 1'b1;
    assign val_x   = {1'b0, value};
    assign step_x  = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    // A step larger than the whole range is clamped to one full revolution.
    assign s_eff   = (step_x < lim_p1) ? step_x : lim_p1;
    assign sum_up  = val_x + s_eff;
    assign wrap_up = sum_up - lim_p1;
    assign diff_dn = val_x - s_eff;
    assign wrap_dn = val_x + lim_p1 - s_eff;

    assign at_zero  = (value == '0);
    assign at_limit = (value == limit);

    // Next-state selection: clear beats load beats counting beats hold.
    always_comb begin
        next_value     = value;
        next_overflow  = 1'b0;
        next_underflow = 1'b0;
        if (clear) begin
            next_value = reverse ? limit : '0;
        end else if (load) begin
            next_value = (load_value > limit) ? limit : load_value;
        end else if (enable) begin
            if (value > limit) begin
                // limit was lowered under us: pull back into range quietly.
                next_value = limit;
            end else if (step != '0) begin
                if (!reverse) begin
                    if (sum_up <= lim_x) begin
                        next_value = sum_up[WIDTH-1:0];
                    end else begin
                        next_overflow = 1'b1;
                        next_value    = (SATURATE != 0) ? limit : wrap_up[WIDTH-1:0];
                    end
                end else begin
                    if (val_x >= s_eff) begin
                        next_value = diff_dn[WIDTH-1:0];
                    end else begin
                        next_underflow = 1'b1;
                        next_value     = (SATURATE != 0) ? '0 : wrap_dn[WIDTH-1:0];
                    end
                end
            end
        end
    end

    // Count register and event flags, cleared at once by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value     <= RESET_V;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            value     <= next_value;
            overflow  <= next_overflow;
            underflow <= next_underflow;
        end
    end

endmodule

// File: tb/tb_updn_counter_param.sv
// tb/tb_updn_counter_param.sv - scoreboard bench for updn_counter_param in wrap and saturate builds
module tb_updn_counter_param;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       reverse = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'd0;
    logic [3:0] step = 4'd0;
    logic [7:0] limit = 8'd255;

    logic [7:0] value_w, value_s;
    logic       az_w, al_w, ov_w, uf_w;
    logic       az_s, al_s, ov_s, uf_s;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int v_w;
        bit ov_w;
        bit uf_w;
        int v_s;
        bit ov_s;
        bit uf_s;
        int lim;
    } exp_t;

    exp_t sb[$];

    int model_w = 0;
    int model_s = 0;

    updn_counter_param #(.WIDTH(8), .STEP_W(4), .SATURATE(0), .RESET_VALUE(0)) u_wrap (
        .clock(clock), .reset(reset), .enable(enable), .reverse(reverse),
        .clear(clear), .load(load), .load_value(load_value), .step(step),
        .limit(limit), .value(value_w), .at_zero(az_w), .at_limit(al_w),
        .overflow(ov_w), .underflow(uf_w)
    );

    updn_counter_param #(.WIDTH(8), .STEP_W(4), .SATURATE(1), .RESET_VALUE(0)) u_sat (
        .clock(clock), .reset(reset), .enable(enable), .reverse(reverse),
        .clear(clear), .load(load), .load_value(load_value), .step(step),
        .limit(limit), .value(value_s), .at_zero(az_s), .at_limit(al_s),
        .overflow(ov_s), .underflow(uf_s)
    );

    always #5 clock = ~clock;

    // Reference: counting on the range 0..lim using plain integers.
    function automatic void ref_next(input bit sat, input int v, input bit en, input bit rev,
                                     input bit clr, input bit ld, input int lv, input int st,
                                     input int lim, output int nv, output bit ov, output bit uf);
        int s;
        int range;
        nv = v;
        ov = 1'b0;
        uf = 1'b0;
        range = lim + 1;
        s = (st < range) ? st : range;
        if (clr) nv = rev ? lim : 0;
        else if (ld) nv = (lv < lim) ? lv : lim;
        else if (en) begin
            if (v > lim) nv = lim;
            else if (st != 0) begin
                if (!rev) begin
                    if (v + s <= lim) nv = v + s;
                    else begin
                        ov = 1'b1;
                        nv = sat ? lim : (v + s) % range;
                    end
                end else begin
                    if (v >= s) nv = v - s;
                    else begin
                        uf = 1'b1;
                        nv = sat ? 0 : v - s + range;
                    end
                end
            end
        end
    endfunction

    task automatic drive(input bit en, input bit rev, input bit clr, input bit ld,
                         input int lv, input int st, input int lim);
        exp_t e;
        @(negedge clock);
        enable = en;
        reverse = rev;
        clear = clr;
        load = ld;
        load_value = 8'(lv);
        step = 4'(st);
        limit = 8'(lim);
        ref_next(1'b0, model_w, en, rev, clr, ld, lv, st, lim, e.v_w, e.ov_w, e.uf_w);
        ref_next(1'b1, model_s, en, rev, clr, ld, lv, st, lim, e.v_s, e.ov_s, e.uf_s);
        e.lim = lim;
        model_w = e.v_w;
        model_s = e.v_s;
        sb.push_back(e);
    endtask

    task automatic check_reset_state(input string name);
        vectors++;
        if (value_w !== 8'd0 || ov_w !== 1'b0 || uf_w !== 1'b0 ||
            value_s !== 8'd0 || ov_s !== 1'b0 || uf_s !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: wrap v=%0d ov=%b uf=%b sat v=%0d ov=%b uf=%b, required v=0 ov=0 uf=0",
                     name, value_w, ov_w, uf_w, value_s, ov_s, uf_s);
        end
    endtask

    // Monitor: one registered result per clock, compared against the oldest expectation.
    always @(posedge clock) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if (int'(value_w) != e.v_w || ov_w !== e.ov_w || uf_w !== e.uf_w ||
                az_w !== (e.v_w == 0) || al_w !== (e.v_w == e.lim)) begin
                miscompares++;
                $display("FAIL wrap @%0t: v=%0d ov=%b uf=%b az=%b al=%b, required v=%0d ov=%b uf=%b az=%b al=%b",
                         $time, value_w, ov_w, uf_w, az_w, al_w,
                         e.v_w, e.ov_w, e.uf_w, e.v_w == 0, e.v_w == e.lim);
            end
            vectors++;
            if (int'(value_s) != e.v_s || ov_s !== e.ov_s || uf_s !== e.uf_s ||
                az_s !== (e.v_s == 0) || al_s !== (e.v_s == e.lim)) begin
                miscompares++;
                $display("FAIL sat @%0t: v=%0d ov=%b uf=%b az=%b al=%b, required v=%0d ov=%b uf=%b az=%b al=%b",
                         $time, value_s, ov_s, uf_s, az_s, al_s,
                         e.v_s, e.ov_s, e.uf_s, e.v_s == 0, e.v_s == e.lim);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lim_r;
        #1;
        check_reset_state("reset_initial");
        #2;
        reset = 1'b0;

        // Full modulo-256 revolution with step 1.
        for (int i = 0; i < 256; i++) drive(1, 0, 0, 0, 0, 1, 255);

        // limit 9, step 3, up then down.
        drive(0, 0, 1, 0, 0, 0, 9);
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 0, 3, 9);
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0, 3, 9);

        // Saturation near the top and bottom.
        drive(0, 0, 0, 1, 190, 0, 200);
        drive(1, 0, 0, 0, 0, 15, 200);
        drive(1, 0, 0, 0, 0, 15, 200);
        drive(0, 0, 0, 0, 0, 15, 200);
        drive(0, 1, 0, 1, 10, 0, 200);
        drive(1, 1, 0, 0, 0, 15, 200);
        drive(1, 1, 0, 0, 0, 15, 200);

        // Clear beats load; load clamps to limit.
        drive(1, 1, 1, 1, 7, 5, 50);
        drive(0, 0, 0, 1, 99, 0, 50);

        // Runtime limit lowered below the current value.
        drive(0, 0, 0, 1, 40, 0, 255);
        drive(1, 0, 0, 0, 0, 1, 20);
        drive(1, 0, 0, 0, 0, 1, 20);

        // limit 0 pins the counter and every step is an event.
        drive(1, 0, 0, 0, 0, 7, 0);
        drive(1, 1, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0);

        // Async reset mid-count at 123.
        drive(0, 0, 0, 1, 120, 0, 255);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 1, 255);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check_reset_state("reset_async");
        reset = 1'b0;
        model_w = 0;
        model_s = 0;
        drive(1, 0, 0, 0, 0, 1, 255);

        // Randomised traffic with occasional limit changes.
        lim_r = 255;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0: lim_r = 255;
                    1: lim_r = $urandom_range(0, 3);
                    default: lim_r = $urandom_range(0, 255);
                endcase
            end
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 255), $urandom_range(0, 15), lim_r);
        end

        @(posedge clock);
        #4;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
